wb_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single 16-bit register-file write port between three writeback sources (ALU result, memory load, immediate/move path). It drives the select of the 3:1 writeback mux and registers the chosen data, destination address and write enable toward the register file. It sits between the execute/memory stages and the register file write port and applies backpressure to sources that are not granted.

---
 rtl/wb_port_arbiter.sv | 108 ++++++++++
 tb/tb_wb_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin share of the register-file write port
// between ALU, load and immediate writeback sources.
module wb_port_arbiter #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    s_valid,
  input  logic [3*DW-1:0] s_data,
  input  logic [3*AW-1:0] s_addr,
  output logic [2:0]    s_ready,
  input  logic          wb_stall,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic [1:0]    wb_sel
);

  logic [1:0]    ptr;
  logic [1:0]    pe;
  logic [1:0]    o0, o1, o2;
  logic [1:0]    gidx;
  logic [DW-1:0] gdata;
  logic [AW-1:0] gaddr;

  assign pe = (ptr == 2'd3) ? 2'd2 : ptr;

  // Search order after the last grant: ptr+1, ptr+2, ptr (mod 3)
  always_comb begin
    o0 = 2'd0;
    o1 = 2'd1;
    o2 = 2'd2;
    case (pe)
      2'd0: begin
        o0 = 2'd1;
        o1 = 2'd2;
        o2 = 2'd0;
      end
      2'd1: begin
        o0 = 2'd2;
        o1 = 2'd0;
        o2 = 2'd1;
      end
      default: begin
        o0 = 2'd0;
        o1 = 2'd1;
        o2 = 2'd2;
      end
    endcase
  end

  // First valid source in search order wins; none while stalled
  always_comb begin
    gidx = 2'd3;
    if (!wb_stall) begin
      if (s_valid[o0])      gidx = o0;
      else if (s_valid[o1]) gidx = o1;
      else if (s_valid[o2]) gidx = o2;
    end
  end

  assign s_ready = (gidx == 2'd3) ? 3'b000
                                  : (3'b001 << gidx);

  // Writeback mux for the granted source
  always_comb begin
    gdata = s_data[0 +: DW];
    gaddr = s_addr[0 +: AW];
    case (gidx)
      2'd1: begin
        gdata = s_data[DW +: DW];
        gaddr = s_addr[AW +: AW];
      end
      2'd2: begin
        gdata = s_data[2*DW +: DW];
        gaddr = s_addr[2*AW +: AW];
      end
      default: begin
        gdata = s_data[0 +: DW];
        gaddr = s_addr[0 +: AW];
      end
    endcase
  end

  // Output register and pointer; everything holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= 2'd2;
      wb_en   <= 1'b0;
      wb_sel  <= 2'b11;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (!wb_stall) begin
      if (gidx != 2'd3) begin
        ptr     <= gidx;
        wb_en   <= 1'b1;
        wb_sel  <= gidx;
        wb_addr <= gaddr;
        wb_data <= gdata;
      end else begin
        wb_en  <= 1'b0;
        wb_sel <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random checks of wb_port_arbiter
// against a round-robin reference model.
module tb_wb_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    s_valid;
  logic [3*DW-1:0] s_data;
  logic [3*AW-1:0] s_addr;
  logic [2:0]    s_ready;
  logic          wb_stall;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [1:0]    wb_sel;

  wb_port_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_addr(s_addr),
    .s_ready(s_ready),
    .wb_stall(wb_stall),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .wb_sel(wb_sel)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  int m_ptr;
  int m_en;
  int m_sel;
  int m_addr;
  int m_data;
  logic [DW-1:0] d [3];
  logic [AW-1:0] a [3];
  bit pend [3];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic model_reset();
    m_ptr  = 2;
    m_en   = 0;
    m_sel  = 3;
    m_addr = 0;
    m_data = 0;
  endtask

  function automatic int pick();
    if (wb_stall) return 3;
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (s_valid[i]) return i;
    end
    return 3;
  endfunction

  task automatic drive();
    s_data = {d[2], d[1], d[0]};
    s_addr = {a[2], a[1], a[0]};
  endtask

  task automatic check_out(string tag);
    check({tag, "_en"}, 32'(wb_en), 32'(m_en));
    check({tag, "_sel"}, 32'(wb_sel), 32'(m_sel));
    check({tag, "_addr"}, 32'(wb_addr), 32'(m_addr));
    check({tag, "_data"}, 32'(wb_data), 32'(m_data));
  endtask

  task automatic cyc(output int g);
    drive();
    #1;
    g = pick();
    check("s_ready", 32'(s_ready),
          (g < 3) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    if (!wb_stall) begin
      if (g < 3) begin
        m_ptr  = g;
        m_en   = 1;
        m_sel  = g;
        m_addr = a[g];
        m_data = d[g];
      end else begin
        m_en  = 0;
        m_sel = 3;
      end
    end
    @(negedge clk);
    check_out("out");
  endtask

  initial begin
    int g;
    rst_n    = 1'b1;
    s_valid  = 3'b000;
    wb_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d[i] = '0;
      a[i] = '0;
      pend[i] = 1'b0;
    end
    drive();
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_en", 32'(wb_en), 32'd0);
    check("rst_sel", 32'(wb_sel), 32'd3);
    check("rst_addr", 32'(wb_addr), 32'd0);
    check("rst_data", 32'(wb_data), 32'd0);
    rst_n = 1'b1;

    // single source
    s_valid = 3'b010;
    d[1] = 16'h1234;
    a[1] = 3'd5;
    cyc(g);
    check("single_en", 32'(wb_en), 32'd1);
    check("single_sel", 32'(wb_sel), 32'd1);
    check("single_addr", 32'(wb_addr), 32'd5);
    check("single_data", 32'(wb_data), 32'h1234);

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("arst_en", 32'(wb_en), 32'd0);
    check("arst_sel", 32'(wb_sel), 32'd3);
    check("arst_addr", 32'(wb_addr), 32'd0);
    check("arst_data", 32'(wb_data), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // all valid: rotation 0,1,2,0,1,2
    for (int i = 0; i < 3; i++) begin
      d[i] = 16'($urandom);
      a[i] = 3'($urandom);
    end
    s_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      cyc(g);
      check("rot_sel", 32'(wb_sel), 32'(k % 3));
      if (g < 3) begin
        d[g] = 16'($urandom);
        a[g] = 3'($urandom);
      end
    end

    // stall three cycles, then resume at src0
    wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(g);
      check("stall_en", 32'(wb_en), 32'd1);
      check("stall_sel", 32'(wb_sel), 32'd2);
    end
    wb_stall = 1'b0;
    cyc(g);
    check("resume_sel", 32'(wb_sel), 32'd0);

    // idle, then src1, then lone src2
    s_valid = 3'b000;
    cyc(g);
    check("idle_en", 32'(wb_en), 32'd0);
    check("idle_sel", 32'(wb_sel), 32'd3);
    s_valid = 3'b010;
    cyc(g);
    s_valid = 3'b100;
    cyc(g);
    check("src2_sel", 32'(wb_sel), 32'd2);

    // same-address collision from ptr=2
    s_valid = 3'b101;
    a[0] = 3'd3;
    a[2] = 3'd3;
    d[0] = 16'hAAAA;
    d[2] = 16'h5555;
    cyc(g);
    check("col1_data", 32'(wb_data), 32'hAAAA);
    s_valid = 3'b100;
    cyc(g);
    check("col2_data", 32'(wb_data), 32'h5555);
    check("col2_addr", 32'(wb_addr), 32'd3);

    // random traffic with sources holding until granted
    s_valid = 3'b000;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          d[i] = 16'($urandom);
          a[i] = 3'($urandom);
        end
        s_valid[i] = pend[i];
      end
      wb_stall = ($urandom_range(0, 3) == 0);
      cyc(g);
      if (g < 3) pend[g] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
